// File: rtl/priority_decoder.sv
// Two-entry FIFO of 3-bit priority codes feeding a one-hot decoder whose
// output is held for a minimum number of cycles before a handshake releases it.
module priority_decoder #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] code,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] dout,
  output logic       out_none,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] level
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    WAIT = 2'd2
  } state_t;

  // HOLD_CYCLES=0 skips HOLD entirely, so the reload value is irrelevant then.
  localparam logic [3:0] HOLD_LOAD = (HOLD_CYCLES == 32'd0) ? 4'd0 : 4'(HOLD_CYCLES - 32'd1);
  localparam state_t     POP_STATE = (HOLD_CYCLES == 32'd0) ? WAIT : HOLD;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] mem_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] level_q, level_d;
  logic [3:0] dout_q, dout_d;
  logic       none_q, none_d;
  logic       valid_q, valid_d;
  logic       push;
  logic       pop;
  logic [2:0] head;

  // Returns {none, one_hot}.
  function automatic logic [4:0] decode(input logic [2:0] c);
    logic [4:0] r;
    r = 5'b1_0000;
    if (c[2]) begin
      case (c[1:0])
        2'd0:    r = 5'b0_0001;
        2'd1:    r = 5'b0_0010;
        2'd2:    r = 5'b0_0100;
        2'd3:    r = 5'b0_1000;
        default: r = 5'b0_0000;
      endcase
    end else begin
      r = 5'b1_0000;
    end
    return r;
  endfunction

  assign in_ready  = (level_q != 2'd2);
  assign push      = in_valid & in_ready;
  assign head      = mem_q[rd_ptr_q];
  assign dout      = dout_q;
  assign out_none  = none_q;
  assign out_valid = valid_q;
  assign level     = level_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    none_d  = none_q;
    valid_d = valid_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q != 2'd0) begin
          pop             = 1'b1;
          {none_d, dout_d} = decode(head);
          cnt_d           = HOLD_LOAD;
          state_d         = POP_STATE;
          valid_d         = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WAIT: begin
        if (out_ready && (level_q != 2'd0)) begin
          pop             = 1'b1;
          {none_d, dout_d} = decode(head);
          cnt_d           = HOLD_LOAD;
          state_d         = POP_STATE;
          valid_d         = 1'b1;
        end else if (out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 2'd1;
      2'b01:   level_d = level_q - 2'd1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= 3'b000;
      mem_q[1] <= 3'b000;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      level_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= code;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      dout_q  <= 4'b0000;
      none_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      none_q  <= none_d;
      valid_q <= valid_d;
    end
  end

endmodule
